// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers used by the single- and multi-channel controllers.
package fifo_pkg;

  // Width of a channel index; a single channel still gets one select bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_channel_ctrl.sv
// One channel's pointers, occupancy count, status flags and sticky error flags.
// Pointers carry an extra wrap bit so that full and empty are distinguishable
// without sacrificing a storage slot.
module fifo_channel_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_acc,
  input  logic              rd_acc,
  input  logic              ovf_set,
  input  logic              udf_set,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   count,
  output fifo_status_t      status,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AF_L = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_L = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;

  // Pointer and count update; flush returns the channel to its reset state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + ONE;
      if (rd_acc) rptr <= rptr + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a new error in the same cycle outranks the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

  assign waddr = wptr[ADDR_W-1:0];
  assign raddr = rptr[ADDR_W-1:0];

  assign status.empty        = (wptr == rptr);
  assign status.full         = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) &&
                               (wptr[ADDR_W] != rptr[ADDR_W]);
  assign status.almost_full  = (count >= AF_L);
  assign status.almost_empty = (count <= AE_L);

endmodule

// File: rtl/multi_fifo_controller.sv
// Pointer/flag controller for NUM_CH FIFOs sharing one dual-port RAM.
// Handshake: a request is taken on the rising edge when its *_accept output is
// high during that cycle; accept is a pure function of the request inputs and
// the registered channel state, and the RAM must write/read at the presented
// address on that same edge. rd_valid marks read data one cycle later.
module multi_fifo_controller
  import fifo_pkg::*;
#(
  parameter int  ADDR_W    = 4,
  parameter int  NUM_CH    = 4,
  parameter int  AF_THRESH = 12,
  parameter int  AE_THRESH = 2,
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [CH_W-1:0]              wr_ch,
  input  logic                         rd_en,
  input  logic [CH_W-1:0]              rd_ch,
  input  logic [NUM_CH-1:0]            flush,
  input  logic                         err_clr,
  output logic                         wr_accept,
  output logic                         rd_accept,
  output logic [CH_W+ADDR_W-1:0]       wr_addr,
  output logic [CH_W+ADDR_W-1:0]       rd_addr,
  output logic                         rd_valid,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            empty,
  output logic [NUM_CH-1:0]            almost_full,
  output logic [NUM_CH-1:0]            almost_empty,
  output logic [NUM_CH*(ADDR_W+1)-1:0] count,
  output logic [NUM_CH-1:0]            overflow,
  output logic [NUM_CH-1:0]            underflow
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic [ADDR_W-1:0] waddr_a [NUM_CH];
  logic [ADDR_W-1:0] raddr_a [NUM_CH];
  fifo_status_t      status_a [NUM_CH];

  logic              wr_ok;
  logic              rd_ok;
  logic [ADDR_W-1:0] wsel_addr;
  logic [ADDR_W-1:0] rsel_addr;
  logic              wsel_full;
  logic              wsel_flush;
  logic              rsel_empty;
  logic              rsel_flush;

  assign wr_ok = ({1'b0, wr_ch} < NUM_CH_L);
  assign rd_ok = ({1'b0, rd_ch} < NUM_CH_L);

  // Select the addressed channel's pointer and flags for each port.
  always_comb begin
    wsel_addr  = '0;
    wsel_full  = 1'b0;
    wsel_flush = 1'b0;
    rsel_addr  = '0;
    rsel_empty = 1'b0;
    rsel_flush = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ch == CH_W'(c)) begin
        wsel_addr  = waddr_a[c];
        wsel_full  = status_a[c].full;
        wsel_flush = flush[c];
      end
      if (rd_ch == CH_W'(c)) begin
        rsel_addr  = raddr_a[c];
        rsel_empty = status_a[c].empty;
        rsel_flush = flush[c];
      end
    end
  end

  assign wr_accept = wr_en & wr_ok & ~wsel_full  & ~wsel_flush;
  assign rd_accept = rd_en & rd_ok & ~rsel_empty & ~rsel_flush;
  assign wr_addr   = {wr_ch, wsel_addr};
  assign rd_addr   = {rd_ch, rsel_addr};

  // Sync-RAM read latency: data for an accepted read appears one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_valid <= 1'b0;
    else       rd_valid <= rd_accept;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic IS_CH0 = (c == 0);
    logic wr_hit;
    logic rd_hit;
    logic ovf_set;
    logic udf_set;
    logic [ADDR_W:0] cnt;

    assign wr_hit  = wr_en & wr_ok & (wr_ch == CH_W'(c));
    assign rd_hit  = rd_en & rd_ok & (rd_ch == CH_W'(c));
    // Flush suppresses the error as well as the request; bad channels report on ch0.
    assign ovf_set = (wr_hit & status_a[c].full  & ~flush[c]) | (IS_CH0 & wr_en & ~wr_ok);
    assign udf_set = (rd_hit & status_a[c].empty & ~flush[c]) | (IS_CH0 & rd_en & ~rd_ok);

    fifo_channel_ctrl #(
      .ADDR_W   (ADDR_W),
      .AF_THRESH(AF_THRESH),
      .AE_THRESH(AE_THRESH)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush[c]),
      .wr_acc   (wr_hit & wr_accept),
      .rd_acc   (rd_hit & rd_accept),
      .ovf_set  (ovf_set),
      .udf_set  (udf_set),
      .err_clr  (err_clr),
      .waddr    (waddr_a[c]),
      .raddr    (raddr_a[c]),
      .count    (cnt),
      .status   (status_a[c]),
      .overflow (overflow[c]),
      .underflow(underflow[c])
    );

    assign full[c]         = status_a[c].full;
    assign empty[c]        = status_a[c].empty;
    assign almost_full[c]  = status_a[c].almost_full;
    assign almost_empty[c] = status_a[c].almost_empty;
    assign count[c*(ADDR_W+1) +: ADDR_W+1] = cnt;
  end

endmodule

// File: tb/tb_multi_fifo_controller.sv
// Directed bench for multi_fifo_controller with a behavioural sync RAM attached.
module tb_multi_fifo_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, rd_en, err_clr;
  logic [1:0]  wr_ch, rd_ch;
  logic [3:0]  flush;
  logic        wr_accept, rd_accept, rd_valid;
  logic [5:0]  wr_addr, rd_addr;
  logic [3:0]  full, empty, almost_full, almost_empty, overflow, underflow;
  logic [19:0] count;

  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic [7:0]  ram [64];
  logic [7:0]  exp_q [$];
  logic [7:0]  m0 [$];

  int errors = 0;
  int checks = 0;

  multi_fifo_controller dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .rd_en(rd_en),
    .rd_ch(rd_ch), .flush(flush), .err_clr(err_clr), .wr_accept(wr_accept),
    .rd_accept(rd_accept), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural dual-port sync RAM driven by the controller
  always @(posedge clk) begin
    if (wr_accept) ram[wr_addr] <= wr_data;
    if (rd_accept) rd_data <= ram[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] cnt(input int c);
    return count[c*5 +: 5];
  endfunction

  // scoreboard: every rd_valid must match the oldest expected read datum
  always @(negedge clk) begin
    if (!reset && rd_valid) begin
      if (exp_q.size() == 0) check("rd_valid_unexpected", 32'd1, 32'd0);
      else check("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // driver: one cycle of requests, accept checks, then the clock edge
  task automatic step(input logic we, input int wch, input logic re, input int rch,
                      input logic [3:0] fl, input logic ec, input logic [7:0] wd,
                      input logic exp_wa, input logic exp_ra, input logic [7:0] exp_d);
    logic [31:0] wc;
    logic [31:0] rc;
    wc = wch;
    rc = rch;
    wr_en = we; wr_ch = wc[1:0]; rd_en = re; rd_ch = rc[1:0];
    flush = fl; err_clr = ec; wr_data = wd;
    #1;
    check("wr_accept", {31'd0, wr_accept}, {31'd0, exp_wa});
    check("rd_accept", {31'd0, rd_accept}, {31'd0, exp_ra});
    if (exp_ra) exp_q.push_back(exp_d);
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 4'd0; err_clr = 1'b0;
  endtask

  task automatic wr(input int ch, input logic [7:0] d, input logic exp_wa);
    step(1'b1, ch, 1'b0, 0, 4'd0, 1'b0, d, exp_wa, 1'b0, 8'd0);
  endtask

  task automatic rd(input int ch, input logic exp_ra, input logic [7:0] d);
    step(1'b0, 0, 1'b1, ch, 4'd0, 1'b0, 8'd0, 1'b0, exp_ra, d);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_ch = 2'd0; rd_ch = 2'd0;
    flush = 4'd0; err_clr = 1'b0; wr_data = 8'd0;
    #2;
    check("rst_count", {12'd0, count}, 32'd0);
    check("rst_empty", {28'd0, empty}, 32'hF);
    check("rst_almost_empty", {28'd0, almost_empty}, 32'hF);
    check("rst_full", {28'd0, full}, 32'd0);
    check("rst_almost_full", {28'd0, almost_full}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_errors", {24'd0, overflow, underflow}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // reset mid-run: ch1 holds 5, a read is in flight
    for (int i = 0; i < 5; i++) wr(1, 8'(8'h10 + i), 1'b1);
    check("ch1_count5", {27'd0, cnt(1)}, 32'd5);
    rd(1, 1'b1, 8'h10);
    check("ch1_rd_valid", {31'd0, rd_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_count", {12'd0, count}, 32'd0);
    check("async_rst_empty", {28'd0, empty}, 32'hF);
    check("async_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;

    // fill ch2 to capacity
    for (int i = 0; i < 16; i++) begin
      wr_ch = 2'd2;
      #1;
      check("ch2_wr_addr", {26'd0, wr_addr}, 32'h20 + i);
      wr(2, 8'(i), 1'b1);
      check("ch2_fill_count", {27'd0, cnt(2)}, i + 1);
      check("ch2_almost_full", {31'd0, almost_full[2]}, (i + 1 >= 12) ? 32'd1 : 32'd0);
      check("ch2_almost_empty", {31'd0, almost_empty[2]}, (i + 1 <= 2) ? 32'd1 : 32'd0);
    end
    check("ch2_full", {28'd0, full}, 32'h4);
    wr(2, 8'hEE, 1'b0);
    check("ch2_overflow", {28'd0, overflow}, 32'h4);
    check("ch2_count16", {27'd0, cnt(2)}, 32'd16);
    for (int i = 0; i < 16; i++) rd(2, 1'b1, 8'(i));
    check("ch2_drained_empty", {31'd0, empty[2]}, 32'd1);
    check("ch2_drained_count", {27'd0, cnt(2)}, 32'd0);

    // ch0 steady state with simultaneous write+read, pointers wrap
    for (int i = 0; i < 3; i++) begin
      wr(0, 8'(8'h30 + i), 1'b1);
      m0.push_back(8'(8'h30 + i));
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 0, 1'b1, 0, 4'd0, 1'b0, 8'(8'h40 + k), 1'b1, 1'b1, m0[0]);
      void'(m0.pop_front());
      m0.push_back(8'(8'h40 + k));
      check("ch0_count_hold", {27'd0, cnt(0)}, 32'd3);
    end
    wr_ch = 2'd0; rd_ch = 2'd0;
    #1;
    check("ch0_wptr_wrapped", {26'd0, wr_addr}, 32'd7);
    check("ch0_rptr_wrapped", {26'd0, rd_addr}, 32'd4);

    // empty ch3: write taken, read rejected, underflow raised
    step(1'b1, 3, 1'b1, 3, 4'd0, 1'b0, 8'h77, 1'b1, 1'b0, 8'd0);
    check("ch3_underflow", {28'd0, underflow}, 32'h8);
    check("ch3_count1", {27'd0, cnt(3)}, 32'd1);

    // ch1 flush beats a simultaneous write
    for (int i = 0; i < 7; i++) wr(1, 8'(8'h60 + i), 1'b1);
    check("ch1_count7", {27'd0, cnt(1)}, 32'd7);
    step(1'b1, 1, 1'b0, 0, 4'b0010, 1'b0, 8'h99, 1'b0, 1'b0, 8'd0);
    check("ch1_flushed_count", {27'd0, cnt(1)}, 32'd0);
    check("ch1_flushed_empty", {31'd0, empty[1]}, 32'd1);
    check("ch1_no_overflow", {31'd0, overflow[1]}, 32'd0);
    check("ch0_untouched", {27'd0, cnt(0)}, 32'd3);
    rd(0, 1'b1, 8'h51);
    rd(0, 1'b1, 8'h52);
    rd(0, 1'b1, 8'h53);
    check("ch0_empty", {31'd0, empty[0]}, 32'd1);

    // sticky flags: set beats clear, clear alone wins next cycle
    for (int i = 0; i < 16; i++) wr(2, 8'(8'hA0 + i), 1'b1);
    step(1'b1, 2, 1'b0, 0, 4'd0, 1'b1, 8'hEE, 1'b0, 1'b0, 8'd0);
    check("ovf_set_beats_clr", {28'd0, overflow}, 32'h4);
    check("udf_cleared", {28'd0, underflow}, 32'd0);
    step(1'b0, 0, 1'b0, 0, 4'd0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0);
    check("ovf_cleared", {28'd0, overflow}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
